// File: rtl/adaptive_green_timer.sv
// Green-time adaptation engine: TG[idx] += (count[idx] - mean) >>> GAIN_SHIFT, saturated to [TG_MIN, TG_MAX].
// Optional macro ADAPT_OVERRIDE_EN adds a direct green-time override port.
module adaptive_green_timer #(
  parameter int NUM_DIR    = 4,
  parameter int CNT_W      = 8,
  parameter int TG_W       = 8,
  parameter int TG_INIT    = 54,
  parameter int TG_MIN     = 10,
  parameter int TG_MAX     = 120,
  parameter int GAIN_SHIFT = 0,
  localparam int IW        = $clog2(NUM_DIR)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      phase_valid,
  input  logic [IW-1:0]             phase_idx,
  input  logic [NUM_DIR*CNT_W-1:0]  cnt_flat,
`ifdef ADAPT_OVERRIDE_EN
  input  logic                      ovr_valid,
  input  logic [IW-1:0]             ovr_idx,
  input  logic [TG_W-1:0]           ovr_tg,
`endif
  output logic                      busy,
  output logic [NUM_DIR*TG_W-1:0]   tg_flat,
  output logic                      upd_valid,
  output logic [IW-1:0]             upd_idx,
  output logic [TG_W-1:0]           upd_tg
);

  localparam int MW = ((TG_W > CNT_W) ? TG_W : CNT_W) + 2;
  localparam int SW = CNT_W + IW;
  localparam logic [IW-1:0]        LAST_IDX = IW'(NUM_DIR - 1);
  localparam logic signed [MW-1:0] MIN_S    = MW'(TG_MIN);
  localparam logic signed [MW-1:0] MAX_S    = MW'(TG_MAX);
  localparam logic [TG_W-1:0]      MIN_U    = TG_W'(TG_MIN);
  localparam logic [TG_W-1:0]      MAX_U    = TG_W'(TG_MAX);
  localparam logic [TG_W-1:0]      INIT_U   = TG_W'(TG_INIT);

  typedef enum logic [1:0] {IDLE, SUM, AVG, UPD} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  snap [NUM_DIR];
  logic [IW-1:0]     idx_q;
  logic [IW-1:0]     ctr;
  logic [SW-1:0]     sum;
  logic [CNT_W-1:0]  avg_q;
  logic [TG_W-1:0]   tg_q [NUM_DIR];

  logic signed [CNT_W:0]  delta;
  logic signed [CNT_W:0]  step;
  logic signed [MW-1:0]   new_val;
  logic [TG_W-1:0]        upd_val;

  // NOTE: state and datapath registers use <= only; blocking assignments in a clocked
  // block create ordering-dependent races between processes.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (phase_valid) state_next = SUM;
      SUM:     if (ctr == LAST_IDX) state_next = AVG;
      AVG:     state_next = UPD;
      UPD:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Signed update is wide enough that tg + step can never wrap before the clamp.
  always_comb begin
    delta   = $signed({1'b0, snap[idx_q]}) - $signed({1'b0, avg_q});
    step    = delta >>> GAIN_SHIFT;
    new_val = $signed({{(MW-TG_W){1'b0}}, tg_q[idx_q]})
            + $signed({{(MW-CNT_W-1){step[CNT_W]}}, step});
    if (new_val < MIN_S)      upd_val = MIN_U;
    else if (new_val > MAX_S) upd_val = MAX_U;
    else                      upd_val = new_val[TG_W-1:0];
  end

`ifdef ADAPT_OVERRIDE_EN
  logic [TG_W-1:0] ovr_clamped;
  always_comb begin
    ovr_clamped = ovr_tg;
    if (ovr_tg < MIN_U)      ovr_clamped = MIN_U;
    else if (ovr_tg > MAX_U) ovr_clamped = MAX_U;
  end
`endif

  // NOTE: the count snapshot, request index and average are fully rewritten before use,
  // so they carry no reset; only architecturally visible state is reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_DIR; k++) tg_q[k] <= INIT_U;
      busy      <= 1'b0;
      upd_valid <= 1'b0;
      upd_idx   <= '0;
      upd_tg    <= INIT_U;
      sum       <= '0;
      ctr       <= '0;
    end else begin
      upd_valid <= 1'b0;
      case (state)
        IDLE: if (phase_valid) begin
          for (int k = 0; k < NUM_DIR; k++) snap[k] <= cnt_flat[k*CNT_W +: CNT_W];
          idx_q <= phase_idx;
          busy  <= 1'b1;
          sum   <= '0;
          ctr   <= '0;
        end
        SUM: begin
          sum <= sum + {{IW{1'b0}}, snap[ctr]};
          ctr <= ctr + 1'b1;
        end
        AVG: avg_q <= CNT_W'(sum >> IW);
        UPD: begin
          tg_q[idx_q] <= upd_val;
          upd_valid   <= 1'b1;
          upd_idx     <= idx_q;
          upd_tg      <= upd_val;
          busy        <= 1'b0;
        end
        default: ;
      endcase
`ifdef ADAPT_OVERRIDE_EN
      // Placed last so an override on the same index as UPD takes precedence.
      if (ovr_valid) begin
        tg_q[ovr_idx] <= ovr_clamped;
        if (state == UPD && ovr_idx == idx_q) upd_tg <= ovr_clamped;
      end
`endif
    end
  end

  for (genvar g = 0; g < NUM_DIR; g++) begin : g_tg_out
    assign tg_flat[g*TG_W +: TG_W] = tg_q[g];
  end

endmodule
